// File: rtl/mem_responder.sv
// mem_responder: multi-cycle memory target for loads, stores and wrapping burst line fills.
// One request at a time moves IDLE -> WAIT (fixed access latency) -> XFER (response beats).
// Burst reads return the addressed word first and wrap inside the aligned block.
module mem_responder #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_burst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  output logic [15:0]       resp_rdata,
  output logic              resp_last,
  output logic              busy
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned WORD_W = ADDR_W - 1;
  localparam int unsigned DEPTH  = 2 ** WORD_W;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LB     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_XFER
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WORD_W-1:0]   word_q;
  logic [WORD_W-1:0]   word_d;
  logic [LB-1:0]       beat_q;
  logic                wr_q;
  logic                burst_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic                resp_last_q;
  logic                busy_q;
  logic                mem_we;
  logic [LB-1:0]       low_inc;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Byte address bit 0 is ignored: every access is word aligned.
  logic unused_addr_lsb;
  assign unused_addr_lsb = req_addr[0];

  // Next beat address: increment only the in-block bits so the burst wraps.
  always_comb begin
    low_inc = LB'(word_q[LB-1:0] + LB'(1));
    word_d  = {word_q[WORD_W-1:LB], low_inc};
  end

  // Store commits on the edge that leaves WAIT.
  assign mem_we = (state_q == S_WAIT) && (cnt_q == '0) && wr_q;

  // Backing array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[word_q] <= wdata_q;
    end
  end

  // Transaction FSM with registered handshake and response flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      word_q       <= '0;
      beat_q       <= '0;
      wr_q         <= 1'b0;
      burst_q      <= 1'b0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            word_q      <= req_addr[ADDR_W-1:1];
            wr_q        <= req_wr;
            burst_q     <= req_burst & ~req_wr;
            wdata_q     <= req_wdata;
            cnt_q       <= CNT_W'(LATENCY - 1);
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            beat_q       <= '0;
            resp_valid_q <= 1'b1;
            resp_last_q  <= ~burst_q;
            state_q      <= S_XFER;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_XFER: begin
          if (resp_last_q) begin
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            word_q      <= word_d;
            beat_q      <= beat_q + LB'(1);
            resp_last_q <= (beat_q == LB'(BURST_LEN - 2));
          end
        end
        default: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_last_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_last  = resp_last_q;
  assign busy       = busy_q;

  // Read data straight from the array at the current beat address; zero on idle and write acks.
  assign resp_rdata = (resp_valid_q && !wr_q) ? mem_q[word_q] : '0;

endmodule
